// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates the receiver, buffers completed bytes in a
// first-word-fall-through FIFO, and tracks overrun, framing and idle-line status.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT_TICKS = 160,
  parameter int DATA_W        = 8
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          clr_status,
  input  logic                          s_tick,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic                          rx_err,
  input  logic [DATA_W-1:0]             rx_data,
  output logic                          rx_enabled,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          idle_timeout,
  output logic [1:0]                    state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    RECV     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                done_q;
  logic                done_rise;
  logic                push_req, push_ok, pop;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_q;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [TW-1:0]       to_cnt;
  logic                armed_q;
  logic                tick_en;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= DISABLED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = IDLE;
        IDLE:     if (rx_busy)   state_d = RECV;
        RECV:     if (done_rise) state_d = IDLE;
        default:  state_d = DISABLED;
      endcase
    end
  end

  assign rx_enabled = (state_q != DISABLED);
  assign state      = state_q;

  // ---------------- push / pop qualification ----------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) done_q <= 1'b0;
    else       done_q <= rx_done;
  end

  assign done_rise = rx_done & ~done_q;
  // A done seen while disabled, or in the cycle enable drops, is discarded.
  assign push_req  = done_rise & enable & (state_q != DISABLED);
  assign pop       = rd_en & ~fifo_empty & ~flush;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req & (~fifo_full | pop) & ~flush;

  // ---------------- FIFO ----------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  assign rd_data    = mem[rd_ptr];
  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  // ---------------- sticky status ----------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop && !flush) overrun <= 1'b1;
      else if (clr_status)                         overrun <= 1'b0;
      if (push_req && rx_err && !flush)            frame_err <= 1'b1;
      else if (clr_status)                         frame_err <= 1'b0;
    end
  end

  // ---------------- idle-line timeout ----------------
  // Armed by each stored byte; fires once per idle gap.
  assign tick_en = s_tick & (state_q == IDLE) & ~fifo_empty & armed_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      to_cnt       <= '0;
      armed_q      <= 1'b0;
      idle_timeout <= 1'b0;
    end else begin
      idle_timeout <= 1'b0;
      if (push_ok) armed_q <= 1'b1;
      if (rx_busy || push_req || flush || (state_q != IDLE)) begin
        to_cnt <= '0;
      end else if (tick_en) begin
        if (to_cnt == TW'(TIMEOUT_TICKS - 1)) begin
          to_cnt       <= '0;
          armed_q      <= 1'b0;
          idle_timeout <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: receiver handshake is driven directly and
// every expected value is hand-computed.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       enable, flush, clr_status, s_tick;
  logic       rx_busy, rx_done, rx_err;
  logic [7:0] rx_data;
  logic       rx_enabled, rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty, fifo_full;
  logic [3:0] fifo_count;
  logic       overrun, frame_err, idle_timeout;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int pulses;

  uart_rx_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_TICKS(160), .DATA_W(8)) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .flush(flush),
    .clr_status(clr_status), .s_tick(s_tick), .rx_busy(rx_busy),
    .rx_done(rx_done), .rx_err(rx_err), .rx_data(rx_data),
    .rx_enabled(rx_enabled), .rd_en(rd_en), .rd_data(rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overrun(overrun), .frame_err(frame_err), .idle_timeout(idle_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // busy for one cycle, then a single-cycle done carrying the byte
  task automatic send_byte(input logic [7:0] d, input logic e);
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0; rx_data = d; rx_err = e; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rx_err = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; enable = 0; flush = 0; clr_status = 0; s_tick = 0;
    rx_busy = 0; rx_done = 0; rx_err = 0; rx_data = 8'h00; rd_en = 0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_rx_enabled", rx_enabled, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_timeout", idle_timeout, 0);
    rstN = 1'b1;
    tick();

    // enable, two bytes, FWFT head and pop
    enable = 1'b1;
    tick();
    chk("en_state", state, 1);
    chk("en_rx_enabled", rx_enabled, 1);
    send_byte(8'hA5, 1'b0);
    chk("first_vis_empty", fifo_empty, 0);
    send_byte(8'h5A, 1'b0);
    chk("two_count", fifo_count, 2);
    chk("two_head", rd_data, 8'hA5);
    chk("back_idle", state, 1);
    pop_one();
    chk("pop_head", rd_data, 8'h5A);
    chk("pop_count", fifo_count, 1);
    chk("two_overrun", overrun, 0);
    chk("two_frame_err", frame_err, 0);
    pop_one();
    chk("drain_empty", fifo_empty, 1);
    pop_one();
    chk("pop_empty_noop", fifo_count, 0);

    // overflow: 9 bytes into 8 entries
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_overrun", overrun, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), rd_data, i);
      pop_one();
    end
    chk("ovf_drained", fifo_empty, 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clr_overrun", overrun, 0);

    // full FIFO, pop and push in the same cycle
    for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i), 1'b0);
    chk("fill_full", fifo_full, 1);
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0; rx_data = 8'h78; rx_done = 1'b1; rd_en = 1'b1;
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    chk("pp_count", fifo_count, 8);
    chk("pp_overrun", overrun, 0);
    chk("pp_head", rd_data, 8'h71);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("pp_pop%0d", i), rd_data, 8'h70 + i);
      pop_one();
    end
    chk("pp_empty", fifo_empty, 1);

    // idle timeout: one pulse after 160 ticks, none more until re-armed
    send_byte(8'h12, 1'b0);
    pulses = 0;
    for (int i = 1; i <= 160; i++) begin
      s_tick = 1'b1;
      tick();
      if (i < 160) begin
        if (idle_timeout) pulses++;
      end else begin
        chk("to_pulse_at_160", idle_timeout, 1);
      end
      s_tick = 1'b0;
      tick();
      chk("to_one_cycle", idle_timeout, 0);
    end
    chk("to_no_early", pulses, 0);
    for (int i = 0; i < 200; i++) begin
      s_tick = 1'b1;
      tick();
      if (idle_timeout) pulses++;
      s_tick = 1'b0;
      tick();
    end
    chk("to_no_second", pulses, 0);
    send_byte(8'h34, 1'b0);
    for (int i = 0; i < 160; i++) begin
      s_tick = 1'b1;
      tick();
      if (idle_timeout) pulses++;
      s_tick = 1'b0;
      tick();
    end
    chk("to_rearmed", pulses, 1);
    chk("to_count", fifo_count, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", fifo_count, 0);

    // disable mid-frame: done is ignored, contents kept
    send_byte(8'h21, 1'b0);
    rx_busy = 1'b1;
    tick();
    chk("mid_recv", state, 2);
    enable = 1'b0;
    tick();
    chk("dis_rx_enabled", rx_enabled, 0);
    chk("dis_state", state, 0);
    rx_busy = 1'b0; rx_data = 8'h56; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    chk("dis_count", fifo_count, 1);
    chk("dis_head", rd_data, 8'h21);
    enable = 1'b1;
    tick();
    chk("reen_state", state, 1);

    // level-held done pushes once
    rx_data = 8'h33; rx_done = 1'b1;
    tick(); tick(); tick();
    rx_done = 1'b0;
    tick();
    chk("level_done_count", fifo_count, 2);

    // framing error byte still stored
    send_byte(8'hFF, 1'b1);
    chk("ferr_flag", frame_err, 1);
    chk("ferr_count", fifo_count, 3);
    pop_one();
    pop_one();
    chk("ferr_byte", rd_data, 8'hFF);
    flush = 1'b1; rd_en = 1'b1;
    tick();
    flush = 1'b0; rd_en = 1'b0;
    chk("flush_pop_count", fifo_count, 0);
    chk("flush_pop_empty", fifo_empty, 1);

    // asynchronous reset mid-frame
    send_byte(8'h44, 1'b0);
    rx_busy = 1'b1;
    tick();
    #2 rstN = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_rx_enabled", rx_enabled, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_empty", fifo_empty, 1);
    chk("arst_frame_err", frame_err, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_timeout", idle_timeout, 0);
    rx_busy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
